// File: rtl/vic_wb4.sv
// vic_wb4: four-input fixed-priority vectored interrupt controller.
//   clk_p        : system clock, rising edge
//   rst          : synchronous active-high reset
//   ireq[3:0]    : level requests, bit 0 highest priority
//   dev_ack[3:0] : one-cycle acknowledge to the serviced device
//   virq         : interrupt request to the CPU
//   istb         : vector read strobe from the CPU
//   ivec[15:0]   : vector to the CPU, zero whenever iack is low
//   iack         : vector acknowledge to the CPU
module vic_wb4 #(
    parameter logic [15:0] VEC0      = 16'o000060,
    parameter logic [15:0] VEC1      = 16'o000064,
    parameter logic [15:0] VEC2      = 16'o000100,
    parameter logic [15:0] VEC3      = 16'o000104,
    parameter logic [15:0] STRAY_VEC = 16'o000000
) (
    input  logic        clk_p,
    input  logic        rst,
    input  logic [3:0]  ireq,
    output logic [3:0]  dev_ack,
    output logic        virq,
    input  logic        istb,
    output logic [15:0] ivec,
    output logic        iack
);
    typedef enum logic [1:0] {IDLE, REQ, ACK, RELEASE} state_t;
    state_t      state, state_n;
    logic [1:0]  win, win_n, pick;
    logic [15:0] win_vec, ivec_n;
    logic [3:0]  dev_ack_n;
    logic        virq_n, iack_n, armed, stb;
    assign pick    = ireq[0] ? 2'd0 : ireq[1] ? 2'd1 : ireq[2] ? 2'd2 : 2'd3;
    assign win_vec = win == 2'd0 ? VEC0 : win == 2'd1 ? VEC1 : win == 2'd2 ? VEC2 : VEC3;
    // A strobe still high across reset is ignored until it has been seen low.
    assign stb     = istb & armed;
    always_ff @(posedge clk_p) begin
        if (rst) begin
            state   <= IDLE;
            win     <= 2'd0;
            virq    <= 1'b0;
            iack    <= 1'b0;
            ivec    <= 16'd0;
            dev_ack <= 4'd0;
            armed   <= 1'b0;
        end else begin
            state   <= state_n;
            win     <= win_n;
            virq    <= virq_n;
            iack    <= iack_n;
            ivec    <= ivec_n;
            dev_ack <= dev_ack_n;
            armed   <= armed | ~istb;
        end
    end
    always_comb begin
        state_n   = state;
        win_n     = win;
        virq_n    = 1'b0;
        iack_n    = iack;
        ivec_n    = ivec;
        dev_ack_n = 4'd0;
        case (state)
            IDLE:
                if (stb) begin
                    state_n = ACK;
                    iack_n  = 1'b1;
                    ivec_n  = STRAY_VEC;
                end else if (|ireq) begin
                    state_n = REQ;
                    win_n   = pick;
                    virq_n  = 1'b1;
                end
            REQ:
                // The strobe serves the already latched winner, ignoring this cycle's ireq.
                if (stb) begin
                    state_n   = ACK;
                    iack_n    = 1'b1;
                    ivec_n    = win_vec;
                    dev_ack_n = 4'b0001 << win;
                end else if (|ireq) begin
                    win_n  = pick;
                    virq_n = 1'b1;
                end else begin
                    state_n = IDLE;
                end
            ACK:
                if (!istb) begin
                    state_n = RELEASE;
                    iack_n  = 1'b0;
                    ivec_n  = 16'd0;
                end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_vic_wb4.sv
// tb_vic_wb4: scoreboard-based self-checking bench for vic_wb4.
module tb_vic_wb4;
    localparam logic [15:0] VEC0 = 16'o000060, VEC1 = 16'o000064, VEC2 = 16'o000100,
                            VEC3 = 16'o000104, STRAY = 16'o000000;
    logic        clk_p = 1'b0, rst = 1'b1, istb = 1'b0, virq, iack;
    logic [3:0]  ireq = 4'd0, dev_ack;
    logic [15:0] ivec;
    int          checks = 0, errors = 0;
    typedef struct {logic [15:0] vec; logic [3:0] ack;} exp_t;
    exp_t exp_q[$];
    exp_t e;

    vic_wb4 dut (.clk_p(clk_p), .rst(rst), .ireq(ireq), .dev_ack(dev_ack), .virq(virq),
                 .istb(istb), .ivec(ivec), .iack(iack));

    always #5 clk_p = ~clk_p;

    always @(negedge clk_p) if (!rst) begin
        checks++;
        if ((virq && iack) || (!iack && ivec !== 16'd0) || (dev_ack & (dev_ack - 4'd1)) !== 4'd0) begin
            errors++;
            $display("FAIL invariant: virq=%b iack=%b ivec=%o dev_ack=%b", virq, iack, ivec, dev_ack);
        end
    end

    task automatic tick(int n = 1);
        repeat (n) begin @(posedge clk_p); #1; end
    endtask

    task automatic strobe(string name, logic [15:0] vec, logic [3:0] ack);
        istb = 1'b1;
        exp_q.push_back('{vec, ack});
        tick();
        e = exp_q.pop_front();
        checks++;
        if ({iack, virq, ivec, dev_ack} !== {2'b10, e.vec, e.ack}) begin
            errors++;
            $display("FAIL %s: got iack=%b virq=%b ivec=%o dev_ack=%b, want iack=1 virq=0 ivec=%o dev_ack=%b",
                     name, iack, virq, ivec, dev_ack, e.vec, e.ack);
        end
    endtask

    task automatic expect_bit(string name, logic got, logic want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %b, want %b", name, got, want);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick(2);
        checks++;
        if ({virq, iack, ivec, dev_ack} !== 22'd0) begin
            errors++;
            $display("FAIL reset: got virq=%b iack=%b ivec=%o dev_ack=%b, want all 0", virq, iack, ivec, dev_ack);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single;
        ireq = 4'b0100;
        tick();
        expect_bit("single_virq", virq, 1'b1);
        strobe("single_ack", VEC2, 4'b0100);
        ireq = 4'b0000;
        tick();
        checks++;
        if ({iack, ivec, dev_ack} !== {1'b1, VEC2, 4'b0000}) begin
            errors++;
            $display("FAIL single_hold: got iack=%b ivec=%o dev_ack=%b, want iack=1 ivec=%o dev_ack=0000",
                     iack, ivec, dev_ack, VEC2);
        end
        istb = 1'b0;
        tick();
        expect_bit("single_iack_fall", iack, 1'b0);
        checks++;
        if (ivec !== 16'd0) begin
            errors++;
            $display("FAIL single_ivec_clear: got %o, want 0", ivec);
        end
        tick(2);
    endtask

    task automatic test_priority;
        ireq = 4'b1010;
        tick();
        expect_bit("prio_virq", virq, 1'b1);
        strobe("prio_first", VEC1, 4'b0010);
        ireq = 4'b1000;
        istb = 1'b0;
        tick(2);
        expect_bit("prio_gap", virq, 1'b0);
        tick();
        expect_bit("prio_virq2", virq, 1'b1);
        strobe("prio_second", VEC3, 4'b1000);
        ireq = 4'b0000;
        istb = 1'b0;
        tick(3);
    endtask

    task automatic test_late_priority;
        ireq = 4'b1000;
        tick();
        expect_bit("late_virq", virq, 1'b1);
        tick(3);
        ireq = 4'b1001;
        tick();
        strobe("late_ack", VEC0, 4'b0001);
        ireq = 4'b0000;
        istb = 1'b0;
        tick(3);
    endtask

    task automatic test_simultaneous;
        ireq = 4'b0100;
        tick();
        ireq = 4'b0101;
        strobe("simul_newreq", VEC2, 4'b0100);
        ireq = 4'b0000;
        istb = 1'b0;
        tick(3);
        ireq = 4'b0010;
        tick();
        ireq = 4'b0000;
        strobe("simul_withdraw", VEC1, 4'b0010);
        istb = 1'b0;
        tick(3);
        expect_bit("simul_idle", virq, 1'b0);
    endtask

    task automatic test_withdraw_stray;
        ireq = 4'b0010;
        tick();
        expect_bit("wd_virq", virq, 1'b1);
        tick();
        ireq = 4'b0000;
        tick();
        expect_bit("wd_virq_fall", virq, 1'b0);
        tick();
        strobe("stray", STRAY, 4'b0000);
        istb = 1'b0;
        tick();
        expect_bit("stray_iack_fall", iack, 1'b0);
        tick(2);
    endtask

    task automatic test_reset_mid;
        ireq = 4'b0001;
        tick();
        strobe("mid_ack", VEC0, 4'b0001);
        rst = 1'b1;
        tick();
        checks++;
        if ({virq, iack, ivec, dev_ack} !== 22'd0) begin
            errors++;
            $display("FAIL mid_reset: got virq=%b iack=%b ivec=%o dev_ack=%b, want all 0", virq, iack, ivec, dev_ack);
        end
        rst = 1'b0;
        ireq = 4'b0000;
        tick(3);
        expect_bit("mid_no_stray", iack, 1'b0);
        ireq = 4'b0001;
        tick();
        expect_bit("mid_virq", virq, 1'b1);
        tick(2);
        expect_bit("mid_still_no_iack", iack, 1'b0);
        istb = 1'b0;
        tick();
        strobe("mid_rearmed", VEC0, 4'b0001);
        ireq = 4'b0000;
        istb = 1'b0;
        tick(3);
    endtask

    task automatic test_back_to_back;
        ireq = 4'b0001;
        tick();
        strobe("b2b_first", VEC0, 4'b0001);
        istb = 1'b0;
        tick();
        expect_bit("b2b_iack_fall", iack, 1'b0);
        expect_bit("b2b_gap1", virq, 1'b0);
        tick();
        expect_bit("b2b_gap2", virq, 1'b0);
        tick();
        expect_bit("b2b_reassert", virq, 1'b1);
        strobe("b2b_second", VEC0, 4'b0001);
        ireq = 4'b0000;
        istb = 1'b0;
        tick(3);
    endtask

    initial begin
        test_reset;
        test_single;
        test_priority;
        test_late_priority;
        test_simultaneous;
        test_withdraw_stray;
        test_reset_mid;
        test_back_to_back;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
